// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional two-entry skid buffer.
// Output fields come straight from the main register. A second skid entry keeps in_ready off the out_ready path.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int EXE_W  = 5,
  parameter int MEM_W  = 2,
  parameter int WB_W   = 2,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXE_W-1:0]  in_exe,
  input  logic [MEM_W-1:0]  in_mem,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_d1,
  input  logic [DATA_W-1:0] in_d2,
  input  logic [DATA_W-1:0] in_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXE_W-1:0]  out_exe,
  output logic [MEM_W-1:0]  out_mem,
  output logic [WB_W-1:0]   out_wb,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_d1,
  output logic [DATA_W-1:0] out_d2,
  output logic [DATA_W-1:0] out_addr,
  output logic [1:0]        occ
);

  localparam int PW = EXE_W + MEM_W + WB_W + 3*REG_W + 3*DATA_W;

  logic [PW-1:0]    w_in_pld;
  logic [PW-1:0]    r_main_pld;
  logic [PW-1:0]    r_skid_pld;
  logic             r_main_vld;
  logic             r_skid_vld;
  logic [1:0]       r_occ;
  logic             w_accept;
  logic             w_issue;
  logic             w_main_vld_nxt;
  logic             w_skid_vld_nxt;
  logic             w_main_ld_in;
  logic             w_main_ld_skid;
  logic             w_skid_ld;
  logic [EXE_W-1:0] w_exe;
  logic [MEM_W-1:0] w_mem;
  logic [WB_W-1:0]  w_wb;

  assign w_in_pld = {in_exe, in_mem, in_wb, in_rs, in_rt, in_rd, in_d1, in_d2, in_addr};
  assign {w_exe, w_mem, w_wb, out_rs, out_rt, out_rd, out_d1, out_d2, out_addr} = r_main_pld;

  // Control fields read as a bubble whenever the main entry is empty.
  assign out_exe   = r_main_vld ? w_exe : '0;
  assign out_mem   = r_main_vld ? w_mem : '0;
  assign out_wb    = r_main_vld ? w_wb  : '0;
  assign out_valid = r_main_vld;
  assign occ       = r_occ;

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~r_skid_vld;
    end else begin : g_single
      assign in_ready = ~r_main_vld | out_ready;
    end
  endgenerate

  assign w_accept = in_valid & in_ready;
  assign w_issue  = r_main_vld & out_ready;

  always_comb begin
    w_main_vld_nxt = r_main_vld;
    w_skid_vld_nxt = r_skid_vld;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (flush) begin
      // An accepted payload is consumed and dropped along with held entries.
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (!r_main_vld || w_issue) begin
      if ((SKID != 0) && r_skid_vld) begin
        w_main_ld_skid = 1'b1;
        w_main_vld_nxt = 1'b1;
        w_skid_ld      = w_accept;
        w_skid_vld_nxt = w_accept;
      end else begin
        w_main_ld_in   = w_accept;
        w_main_vld_nxt = w_accept;
      end
    end else if ((SKID != 0) && w_accept) begin
      w_skid_ld      = 1'b1;
      w_skid_vld_nxt = 1'b1;
    end
  end

  // Stage boundary: main and skid entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_occ      <= 2'd0;
      r_main_pld <= '0;
      r_skid_pld <= '0;
    end else begin
      r_main_vld <= w_main_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      r_occ      <= {1'b0, w_main_vld_nxt} + {1'b0, w_skid_vld_nxt};
      if (w_main_ld_skid) begin
        r_main_pld <= r_skid_pld;
      end else if (w_main_ld_in) begin
        r_main_pld <= w_in_pld;
      end
      if (w_skid_ld) begin
        r_skid_pld <= w_in_pld;
      end
    end
  end

endmodule
